// File: rtl/int_div_rem_arb_pkg.sv
// Shared types for the divider/remainder arbiter: FSM state encoding and
// the width helper used to size requester indices.
package int_div_rem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // A single requester still needs a 1-bit index so port widths stay legal.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_div_rem_arbiter_round_robin_arb.sv
// Combinational round-robin picker: the first set request at or above prio,
// wrapping around, found by rotate / priority-encode / un-rotate.
module round_robin_arb
    import int_div_rem_arb_pkg::*;
#(
    parameter  int nreqs = 4,
    localparam int ow    = owner_width(nreqs)
) (
    input  logic [nreqs-1:0] reqs,
    input  logic [ow-1:0]    prio,
    output logic [ow-1:0]    grant_idx,
    output logic             grant_any
);

    logic [nreqs-1:0] rotated;
    logic [ow-1:0]    enc;
    logic [ow:0]      sum;

    // NOTE: every variable gets a default at the top of the block so no path
    // through it can leave a value unassigned and infer a latch.
    always_comb begin
        rotated = nreqs'({reqs, reqs} >> prio);
        enc     = '0;
        for (int i = nreqs - 1; i >= 0; i--) begin
            if (rotated[i]) enc = ow'(i);
        end
        // Un-rotate with an explicit modulo so non-power-of-two counts wrap.
        sum = {1'b0, prio} + {1'b0, enc};
        if (sum >= (ow + 1)'(nreqs)) sum = sum - (ow + 1)'(nreqs);
        grant_idx = sum[ow-1:0];
        grant_any = |reqs;
    end

endmodule

// File: rtl/int_div_rem_arbiter.sv
// Shares one iterative divider/remainder unit among nreqs val/rdy requesters;
// the granted requester owns the divider until its response is delivered.
module int_div_rem_arbiter
    import int_div_rem_arb_pkg::*;
#(
    parameter int nbits = 64,
    parameter int nreqs = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [nreqs*2*nbits-1:0]   in_req_msg,
    input  logic [nreqs-1:0]           in_req_val,
    output logic [nreqs-1:0]           in_req_rdy,

    output logic [2*nbits-1:0]         out_resp_msg,
    output logic [nreqs-1:0]           out_resp_val,
    input  logic [nreqs-1:0]           out_resp_rdy,

    output logic [2*nbits-1:0]         div_req_msg,
    output logic                       div_req_val,
    input  logic                       div_req_rdy,

    input  logic [2*nbits-1:0]         div_resp_msg,
    input  logic                       div_resp_val,
    output logic                       div_resp_rdy
);

    localparam int mw = 2 * nbits;
    localparam int ow = owner_width(nreqs);

    arb_state_e    state, state_next;
    logic [ow-1:0] owner, owner_next;
    logic [ow-1:0] prio, prio_next;

    logic [ow-1:0] grant_idx;
    logic          grant_any;

    round_robin_arb #(.nreqs(nreqs)) u_rr_arb (
        .reqs      (in_req_val),
        .prio      (prio),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // NOTE: state registers use non-blocking assignments and a synchronous
    // reset, so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            prio  <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            prio  <= prio_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        prio_next  = prio;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    owner_next = grant_idx;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // A withdrawn request gives up the grant without moving prio.
                if (!in_req_val[owner])  state_next = IDLE;
                else if (div_req_rdy)    state_next = WAIT;
            end
            WAIT: begin
                if (div_resp_val && out_resp_rdy[owner]) begin
                    prio_next  = (int'(owner) == nreqs - 1) ? '0 : owner + ow'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request-side outputs see only the owner's valid and the divider's ready,
    // never other requesters, so no combinational path crosses requesters.
    always_comb begin
        in_req_rdy   = '0;
        out_resp_val = '0;
        div_req_val  = 1'b0;
        div_resp_rdy = 1'b0;
        div_req_msg  = in_req_msg[int'(owner)*mw +: mw];
        out_resp_msg = div_resp_msg;
        if (!reset) begin
            case (state)
                ISSUE: begin
                    div_req_val       = in_req_val[owner];
                    in_req_rdy[owner] = div_req_rdy;
                end
                WAIT: begin
                    out_resp_val[owner] = div_resp_val;
                    div_resp_rdy        = out_resp_rdy[owner];
                end
                default: ;
            endcase
        end
    end

endmodule
